// File: rtl/sig_sync_edge_det.sv
// Per-channel STAGES-deep synchroniser, persistence filter, registered level/complement and rise/fall strobes.
// Optional EDGE_CNT_EN adds a channel-0 rising-edge counter with synchronous clear.
module sig_sync_edge_det #(
   parameter int WIDTH    = 1,
   parameter int STAGES   = 2,
   parameter int FILT_LEN = 0,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] sigIn,
   output logic [WIDTH-1:0] sigOut,
   output logic [WIDTH-1:0] sigOut_n,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             edge_any
`ifdef EDGE_CNT_EN
   ,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] edge_cnt
`endif
);

   // FILT_LEN of 0 and 1 both mean a single agreeing sample is enough.
   localparam int FLEN   = (FILT_LEN < 1) ? 1 : FILT_LEN;
   localparam int FW_RAW = $clog2(FILT_LEN + 1);
   localparam int FW     = (FW_RAW < 1) ? 1 : FW_RAW;
   localparam logic [FW-1:0] CNT_TOP = FW'(FLEN - 1);

   logic [WIDTH-1:0] sync_q [STAGES];
   logic [WIDTH-1:0] s_last;
   logic [FW-1:0]    cnt_q  [WIDTH];
   logic [FW-1:0]    cnt_d  [WIDTH];
   logic [WIDTH-1:0] out_d;
   logic [WIDTH-1:0] rise_d;
   logic [WIDTH-1:0] fall_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= sigIn;
         for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign s_last = sync_q[STAGES-1];

   // A differing level must be seen for FLEN consecutive enabled cycles before it is taken.
   always_comb begin
      out_d  = sigOut;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (en) begin
            if (s_last[i] == sigOut[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_TOP) begin
               cnt_d[i]  = '0;
               out_d[i]  = s_last[i];
               rise_d[i] = s_last[i];
               fall_d[i] = ~s_last[i];
            end else begin
               cnt_d[i] = cnt_q[i] + FW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sigOut <= '0;
         rise   <= '0;
         fall   <= '0;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         sigOut <= out_d;
         rise   <= rise_d;
         fall   <= fall_d;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign sigOut_n = ~sigOut;
   assign edge_any = |(rise | fall);

`ifdef EDGE_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         edge_cnt <= '0;
      end else if (clr_cnt) begin
         edge_cnt <= '0;
      end else if (rise[0]) begin
         edge_cnt <= edge_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: doc/sig_sync_edge_det.md
Name: sig_sync_edge_det

Overview:
Parametrised multi-channel successor to the single-bit D flip-flop. Provides per channel:
- a STAGES-deep synchroniser for asynchronous inputs;
- an optional glitch filter;
- a registered output plus its complement;
- one-cycle rise and fall strobes.

It sits between the external reference/feedback inputs and the DPLL phase detector, which consumes the clean levels and edge strobes.

Parameters:
WIDTH, 1, number of independent channels
STAGES, 2, synchroniser depth in flops; legal range 2..4
FILT_LEN, 0, consecutive cycles a new level must persist before acceptance; 0 and 1 both mean no filtering; legal range 0..255
CNT_W, 16, width of edge_cnt (used only with EDGE_CNT_EN)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-low
en  input  1  evaluation enable; synchroniser runs regardless
sigIn  input  WIDTH  asynchronous input levels
sigOut  output  WIDTH  filtered, registered levels
sigOut_n  output  WIDTH  bitwise complement of sigOut
rise  output  WIDTH  one-cycle strobe: sigOut went 0->1 this cycle
fall  output  WIDTH  one-cycle strobe: sigOut went 1->0 this cycle
edge_any  output  1  OR-reduction of rise | fall
clr_cnt  input  1  synchronous clear of edge_cnt (EDGE_CNT_EN only)
edge_cnt  output  CNT_W  channel-0 rising-edge count (EDGE_CNT_EN only)

Behaviour:
- Clock, reset and enable:
  - Clock is clk.
  - reset is asynchronous and active-low. Assertion immediately clears every register: sync chain, filter counters, sigOut, rise, fall, edge_cnt.
  - During reset: sigOut=0, sigOut_n=all ones, rise=fall=0, edge_any=0.
  - Release is synchronous to the next posedge.
- Synchroniser, per channel i:
  - s[0] <= sigIn[i]; s[k] <= s[k-1]; s_last = s[STAGES-1].
  - Updates every cycle, independent of en.
- Filter, per channel, counter cnt of ceil(log2(FILT_LEN+1)) bits, minimum 1:
  - If en=0: cnt, sigOut, rise and fall hold/clear as below; no acceptance.
  - If s_last == sigOut: cnt <= 0.
  - If s_last != sigOut and cnt == max(FILT_LEN,1)-1: sigOut <= s_last; cnt <= 0.
  - Otherwise (differing): cnt <= cnt+1.
- Latency:
  - A clean level change on sigIn set up before edge N appears on sigOut at edge N+STAGES+max(FILT_LEN,1)-1.
  - Default parameters: 2 cycles after edge N, i.e. at edge N+2.
  - A pulse shorter than max(FILT_LEN,1) cycles at s_last never reaches sigOut.
- Strobes:
  - rise/fall are registered and assert in exactly the cycle sigOut first shows the new value; they last 1 cycle.
  - en=0 forces rise=fall=0 on the next edge.
  - rise and fall are never both high on one channel.
- sigOut_n is combinational ~sigOut.
- edge_any is combinational.
- Simultaneous events:
  - Channels are fully independent; several strobes can fire in one cycle.
  - en deasserted in the cycle acceptance would occur: acceptance is suppressed, cnt held, and acceptance happens on the first enabled cycle in which the condition still holds.
- Reset mid-filter:
  - A partially counted change is discarded.
  - After release, sigOut starts at 0. A high input is then accepted with full latency and produces a rise strobe.

Optional Feature:
Macro EDGE_CNT_EN.
- Defined:
  - clr_cnt and edge_cnt ports exist.
  - edge_cnt increments by 1 on each cycle with rise[0]=1 and wraps modulo 2^CNT_W.
  - clr_cnt=1 sets edge_cnt to 0 and takes priority over a simultaneous rise.
  - Reset value is 0.
- Not defined:
  - Ports and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Defaults, reset low then released; sigIn=1 set up before edge 10 -> sigOut=1 and rise=1 at edge 12; rise=0 at edge 13; sigOut_n=0.
- FILT_LEN=4, STAGES=2: a 3-cycle-wide high pulse -> sigOut stays 0, no strobes. A 4-cycle pulse -> sigOut=1 for 4 cycles, then one rise and one fall.
- WIDTH=4: sigIn 0000->0101, later ->1010 -> rise=0101 at first acceptance; then rise=1010 and fall=0101 in the same cycle; edge_any=1 in both cycles.
- en=0 while sigIn toggles 0->1 -> sigOut holds 0, no strobes. en=1 -> sigOut=1 and rise=1 on the next edge.
- Filter mid-count (FILT_LEN=8, cnt=5): reset pulsed low for 1 ns -> all outputs clear immediately; after release a steady sigIn=1 is accepted 10 edges later.
- EDGE_CNT_EN, CNT_W=4: 17 rising edges on channel 0 -> edge_cnt=1. clr_cnt asserted in the same cycle as rise -> edge_cnt=0.
